// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the MIPS execute stage.
// The result is computed when the op starts and held until the countdown expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_Out
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [63:0]   pend_reg, pend_next;
    logic          wr_reg, wr_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;

    logic        is_mult, is_div, div_zero;
    logic [63:0] prod_s, prod_u, op_result;
    logic [31:0] mag_a, mag_b, div_b_s, div_b_u;
    logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;

    assign is_mult  = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    assign is_div   = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    assign div_zero = is_div && (B == 32'd0);

    // Sign-extended unsigned multiply yields the correct 64-bit two's-complement product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    // A zero divisor is replaced by 1 only to keep the dividers defined; the result is discarded.
    assign mag_a   = A[31] ? (~A + 32'd1) : A;
    assign mag_b   = B[31] ? (~B + 32'd1) : B;
    assign div_b_s = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign div_b_u = (B == 32'd0) ? 32'd1 : B;
    assign uq_s    = mag_a / div_b_s;
    assign ur_s    = mag_a % div_b_s;
    assign q_s     = (A[31] ^ B[31]) ? (~uq_s + 32'd1) : uq_s;
    assign r_s     = A[31] ? (~ur_s + 32'd1) : ur_s;
    assign q_u     = A / div_b_u;
    assign r_u     = A % div_b_u;

    always_comb begin
        op_result = 64'd0;
        case (MDOp)
            OP_MULT:  op_result = prod_s;
            OP_MULTU: op_result = prod_u;
            OP_DIV:   op_result = {r_s, q_s};
            OP_DIVU:  op_result = {r_u, q_u};
            default:  op_result = 64'd0;
        endcase
    end

    assign Busy   = (state_reg == RUN);
    assign Start  = En && (is_mult || is_div) && !Busy;
    assign HI     = hi_reg;
    assign LO     = lo_reg;
    assign MD_Out = (MDOp == OP_MFHI) ? hi_reg :
                    (MDOp == OP_MFLO) ? lo_reg : 32'd0;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        pend_next  = pend_reg;
        wr_next    = wr_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                    count_next = is_mult ? MULT_LOAD : DIV_LOAD;
                    pend_next  = op_result;
                    wr_next    = !div_zero;
                end else if (En && MDOp == OP_MTHI) begin
                    hi_next = A;
                end else if (En && MDOp == OP_MTLO) begin
                    lo_next = A;
                end
            end
            RUN: begin
                count_next = count_reg - CNT_ONE;
                if (count_reg == CNT_ONE) begin
                    state_next = IDLE;
                    if (wr_reg) begin
                        hi_next = pend_reg[63:32];
                        lo_next = pend_reg[31:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            pend_reg  <= 64'd0;
            wr_reg    <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            pend_reg  <= pend_next;
            wr_reg    <= wr_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end
endmodule
